// File: rtl/rgb_gray_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rgb_gray_pipe
// Description : RGB888 to 8-bit luminance converter. It has three pipeline
//               stages (products, sum, rounded and saturated result), a
//               valid/ready handshake on both sides, and one global stall.
//               It also carries SOF/EOL flags and keeps a per-frame pixel
//               counter.
//               Optional feature macro: GRAY_ROUND_EN (round half up before
//               the result bits are taken; truncation when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_gray_pipe #(
   parameter logic [7:0] COEF_R = 8'd77,
   parameter logic [7:0] COEF_G = 8'd150,
   parameter logic [7:0] COEF_B = 8'd29
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic        in_sof,
   input  logic        in_eol,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_gray,
   output logic        out_sof,
   output logic        out_eol,
   output logic [19:0] pix_cnt
);

`ifdef GRAY_ROUND_EN
   localparam logic [24:0] ROUND_ADD = 25'h000_8000;
`else
   localparam logic [24:0] ROUND_ADD = 25'h000_0000;
`endif

   logic        stall;
   logic        accept;

   // Product format: pixel*coef shifted up by 8, i.e. a 24-bit Q8.16 value
   logic [23:0] prod_r;
   logic [23:0] prod_g;
   logic [23:0] prod_b;

   logic        s1_valid;
   logic        s1_sof;
   logic        s1_eol;
   logic [23:0] s1_prod_r;
   logic [23:0] s1_prod_g;
   logic [23:0] s1_prod_b;

   logic [24:0] sum_next;
   logic        s2_valid;
   logic        s2_sof;
   logic        s2_eol;
   logic [24:0] s2_sum;

   logic [8:0]  gray_field;
   logic [7:0]  gray_sat;

   // A held output freezes the whole pipe; upstream must hold its pixel
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   assign prod_r = {16'(in_r) * 16'(COEF_R), 8'h00};
   assign prod_g = {16'(in_g) * 16'(COEF_G), 8'h00};
   assign prod_b = {16'(in_b) * 16'(COEF_B), 8'h00};

   // The sum wraps modulo 2^25; the rounding add wraps the same way
   assign sum_next   = 25'(s1_prod_r) + 25'(s1_prod_g) + 25'(s1_prod_b);
   assign gray_field = 9'((s2_sum + ROUND_ADD) >> 16);
   assign gray_sat   = gray_field[8] ? 8'hFF : gray_field[7:0];

   // Stage 1: register the three weighted products and the flags
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         s1_valid  <= 1'b0;
         s1_sof    <= 1'b0;
         s1_eol    <= 1'b0;
         s1_prod_r <= '0;
         s1_prod_g <= '0;
         s1_prod_b <= '0;
      end else if (!stall) begin
         s1_valid  <= accept;
         s1_sof    <= in_sof;
         s1_eol    <= in_eol;
         s1_prod_r <= prod_r;
         s1_prod_g <= prod_g;
         s1_prod_b <= prod_b;
      end
   end

   // Stage 2: register the 25-bit sum of the products
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_eol   <= 1'b0;
         s2_sum   <= '0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_eol   <= s1_eol;
         s2_sum   <= sum_next;
      end
   end

   // Stage 3: register the rounded and saturated luminance
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_gray  <= '0;
      end else if (!stall) begin
         out_valid <= s2_valid;
         out_sof   <= s2_sof;
         out_eol   <= s2_eol;
         out_gray  <= gray_sat;
      end
   end

   // Per-frame pixel counter: SOF pixel restarts at 1, otherwise wraps naturally
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         pix_cnt <= '0;
      end else if (accept) begin
         if (in_sof) begin
            pix_cnt <= 20'd1;
         end else begin
            pix_cnt <= pix_cnt + 20'd1;
         end
      end
   end

endmodule
`default_nettype wire
